tx_device: RTL and testbench
============================

# tx_device

Serial frame transmitter that sits directly upstream of the receive device. It accepts a parallel data word through a valid/ready handshake and emits a one-cycle start strobe. It then serialises the word LSB-first, followed by a stop bit, holding each bit for a fixed number of clocks. Its `tx_start`/`tx_data` outputs wire straight to the receiver's `rx_start`/`rx_data` inputs.

## Interface
- `DATA_BITS`, default 4: payload bits per frame.
- `CLKS_PER_BIT`, default 5: clocks each serial bit is held; legal range 2..16.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_valid`  in  1  `tx_word` is valid.
- `tx_word`  in  DATA_BITS  parallel payload.
- `tx_ready`  out  1  block can accept a word; high only in IDLE.
- `tx_start`  out  1  one-cycle frame-start strobe to the receiver.
- `tx_data`  out  1  serial line; idles high (1).
- `tx_busy`  out  1  frame in progress; high in any state other than IDLE.
- `inject_err`  in  1  present only with `TX_ERR_INJECT_EN` (see Configuration).

## Operation
- States and transitions:
  - IDLE: transitions to START on `tx_valid & tx_ready`.
  - START: lasts one cycle, then moves to DATA.
  - DATA: lasts DATA_BITS×CLKS_PER_BIT cycles, then moves to STOP.
  - STOP: lasts CLKS_PER_BIT cycles, then returns to IDLE.
- Accept: `tx_word` is captured into a DATA_BITS shift register on the handshake edge. `tx_word` and `tx_valid` are ignored while not in IDLE.
- START: `tx_start`=1 and `tx_data`=1.
- DATA: `tx_data` = shift register bit 0. The register shifts right by one when the clock-per-bit counter reaches CLKS_PER_BIT−1. The bit counter increments at the same edge.
- Leaving DATA: occurs when the bit counter reaches DATA_BITS−1 and the clock counter reaches CLKS_PER_BIT−1 together.
- STOP: `tx_data`=1.
- Counters:
  - Clock counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT−1 and wraps to 0.
  - Bit counter is $clog2(DATA_BITS+1) bits wide.
  - Both counters clear on entry to START.
- Outputs are registered. `tx_ready` and `tx_busy` are decoded from the state register.
- Reset values: state IDLE, `tx_start`=0, `tx_data`=1, `tx_ready`=1 (from the first cycle after reset), `tx_busy`=0, counters 0, shift register 0.
- Reset mid-frame: the frame is abandoned. On the next edge the line returns to 1 and no further `tx_start` is issued. The receiver will see a truncated frame; this is acceptable.
- `tx_valid` held high with no gaps: a new word is accepted on the first IDLE cycle after STOP. There are no back-to-back frames without an IDLE cycle.

## Timing
- Take the handshake edge as cycle T.
- T+1: `tx_start`=1.
- Data bit k occupies cycles T+2+k·C through T+1+(k+1)·C, where C = CLKS_PER_BIT.
- Stop bit occupies cycles T+2+DATA_BITS·C through T+1+(DATA_BITS+1)·C.
- `tx_ready` rises at T+2+(DATA_BITS+1)·C.
- With the defaults (DATA_BITS=4, C=5):
  - Frame occupies T+1..T+26.
  - `tx_ready` rises at T+27.
  - Minimum accept-to-accept interval is 27 cycles.
- With CLKS_PER_BIT=5 the receiver's sample counter (0..4) is bit-aligned.

## Configuration
- `TX_ERR_INJECT_EN` defined:
  - Adds the `inject_err` input.
  - `inject_err` is sampled together with `tx_word` on the handshake edge.
  - If it was 1, the whole STOP bit is driven 0, which produces `frame_err` in the downstream receiver. All other timing is unchanged.
- `TX_ERR_INJECT_EN` undefined: the port and flag register do not exist, and the stop bit is always 1.

## Structure
- Package `tx_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, STOP);
  - default constants `TX_DATA_BITS`=4 and `TX_CLKS_PER_BIT`=5;
  - the idle line level constant `TX_LINE_IDLE`=1'b1.
- One sub-module, `tx_bit_timer`, holds the clock-per-bit counter, the bit counter and their terminal-count flags. The top module holds the FSM, the shift register and the output registers.

## Test plan
- Reset, then idle for 10 cycles:
  - `tx_data`=1, `tx_start`=0, `tx_ready`=1, `tx_busy`=0 throughout.
- `tx_word`=4'b1011 accepted at T:
  - `tx_start`=1 only at T+1.
  - `tx_data` reads 1 at T+2..T+6, 1 at T+7..T+11, 0 at T+12..T+16, 1 at T+17..T+21 and 1 (stop) at T+22..T+26.
  - `tx_ready`=1 at T+27.
- `tx_valid` held high with words 4'hA then 4'h5:
  - second accept occurs at T+27;
  - `tx_valid` pulses during T+1..T+26 are ignored.
- Assert `rst` at T+10, mid-frame:
  - next cycle `tx_data`=1, `tx_busy`=0, `tx_ready`=1;
  - no `tx_start` follows.
- Loopback into the receive device with words 0x0..0xF: `frame_err` stays 0 and the received payload equals the sent word.
- `TX_ERR_INJECT_EN` with `inject_err`=1 on word 4'h3:
  - `tx_data`=0 at T+22..T+26;
  - the receiver asserts `frame_err`;
  - the next frame with `inject_err`=0 is clean.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and default constants for the serial frame transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   TX_DATA_BITS    = 4;
  localparam int   TX_CLKS_PER_BIT = 5;
  localparam logic TX_LINE_IDLE    = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Clock-per-bit and bit counters for the transmitter, with terminal-count flags.
module tx_bit_timer
  import tx_pkg::*;
#(
  parameter int DATA_BITS    = TX_DATA_BITS,
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic clk_tc_o,
  output logic bit_tc_o
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_BITS);

  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign clk_tc_o = (clk_cnt_q == CLK_LAST);
  assign bit_tc_o = (bit_cnt_q == BIT_LAST);

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (run_i) begin
      if (clk_tc_o) begin
        clk_cnt_d = '0;
        // Saturate at DATA_BITS so the count stays put through the stop bit.
        if (bit_cnt_q != BIT_END) bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/tx_device.sv
// Serial frame transmitter: start strobe, LSB-first payload, stop bit.
// Optional stop-bit error injection is enabled with TX_ERR_INJECT_EN.
module tx_device
  import tx_pkg::*;
#(
  parameter int DATA_BITS    = TX_DATA_BITS,
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_word,
`ifdef TX_ERR_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic                 tx_ready,
  output logic                 tx_start,
  output logic                 tx_data,
  output logic                 tx_busy
);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_start_q, tx_start_d;
  logic                 tx_data_q, tx_data_d;
  logic                 accept;
  logic                 clk_tc, bit_tc;
  logic                 stop_level;

  assign accept   = (state_q == IDLE) && tx_valid;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

`ifdef TX_ERR_INJECT_EN
  logic err_q, err_d;
  assign err_d      = accept ? inject_err : err_q;
  assign stop_level = err_q ? ~TX_LINE_IDLE : TX_LINE_IDLE;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign stop_level = TX_LINE_IDLE;
`endif

  tx_bit_timer #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .run_i    ((state_q == DATA) || (state_q == STOP)),
    .clk_tc_o (clk_tc),
    .bit_tc_o (bit_tc)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_word;
        end
      end
      START: state_d = DATA;
      DATA: begin
        if (clk_tc) begin
          shift_d = shift_q >> 1;
          if (bit_tc) state_d = STOP;
        end
      end
      STOP: if (clk_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line lines up with the state.
    tx_start_d = (state_d == START);
    case (state_d)
      DATA:    tx_data_d = shift_d[0];
      STOP:    tx_data_d = stop_level;
      default: tx_data_d = TX_LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= TX_LINE_IDLE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_tx_device.sv
// Directed bench for tx_device (default parameters); index n = value seen after handshake edge T+n-1.
module tb_tx_device;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [3:0] tx_word;
  logic       tx_ready, tx_start, tx_data, tx_busy;
`ifdef TX_ERR_INJECT_EN
  logic       inject_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_device dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_word    (tx_word),
`ifdef TX_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a word and returns just after the handshake edge (index 1).
  task automatic do_accept(input logic [3:0] w, input bit keep_valid);
    int b = 0;
    tx_valid = 1'b1;
    tx_word  = w;
    while (!tx_ready && b < 200) begin
      tick();
      b++;
    end
    if (!tx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, b);
    end
    tick();
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int b = 0;
    while (!tx_ready && b < 200) begin
      tick();
      b++;
    end
    if (!tx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: tx_ready=%b, required 1", tx_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({tx_data, tx_start, tx_ready, tx_busy} !== 4'b1010) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: data/start/ready/busy=%b, required 1010", i,
                 {tx_data, tx_start, tx_ready, tx_busy});
      end
    end
  endtask

  task automatic test_frame;
    logic [3:0] w = 4'b1011;
    logic exp_data;
    do_accept(w, 1'b0);
    for (int n = 1; n <= 27; n++) begin
      if (n >= 2 && n <= 21) exp_data = w[(n - 2) / 5];
      else                   exp_data = 1'b1;
      n_tests++;
      if (tx_start !== (n == 1) || tx_data !== exp_data ||
          tx_ready !== (n == 27) || tx_busy !== (n <= 26)) begin
        n_fail++;
        $display("FAIL frame_1011 T+%0d: start/data/ready/busy=%b%b%b%b, required %b%b%b%b", n,
                 tx_start, tx_data, tx_ready, tx_busy, (n == 1), exp_data, (n == 27), (n <= 26));
      end
      if (n < 27) tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a = 4'hA;
    logic exp_data;
    do_accept(a, 1'b1);
    tx_word = 4'h5;
    for (int n = 1; n <= 27; n++) begin
      exp_data = (n >= 2 && n <= 21) ? a[(n - 2) / 5] : 1'b1;
      n_tests++;
      if (tx_start !== (n == 1) || tx_data !== exp_data) begin
        n_fail++;
        $display("FAIL b2b_first T+%0d: start/data=%b%b, required %b%b", n,
                 tx_start, tx_data, (n == 1), exp_data);
      end
      tick();
    end
    n_tests++;
    if (tx_start !== 1'b1 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept T+28: start/ready=%b%b, required 10", tx_start, tx_ready);
    end
    tx_valid = 1'b0;
    tick(); tick();
    n_tests++;
    if (tx_data !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_bit0: tx_data=%b, required 1", tx_data);
    end
    repeat (5) tick();
    n_tests++;
    if (tx_data !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_bit1: tx_data=%b, required 0", tx_data);
    end
    wait_idle();
  endtask

  task automatic test_reset_midframe;
    do_accept(4'h0, 1'b0);
    repeat (9) tick();
    n_tests++;
    if (tx_data !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_pre T+10: data/busy=%b%b, required 01", tx_data, tx_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({tx_data, tx_busy, tx_ready, tx_start} !== 4'b1010) begin
      n_fail++;
      $display("FAIL midframe_reset: data/busy/ready/start=%b, required 1010",
               {tx_data, tx_busy, tx_ready, tx_start});
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_tests++;
      if (tx_start !== 1'b0 || tx_data !== 1'b1) begin
        n_fail++;
        $display("FAIL midframe_after cyc%0d: start/data=%b%b, required 01", i, tx_start, tx_data);
      end
    end
  endtask

  // Bench-side receiver: samples each bit in its middle clock.
  task automatic rx_model(output logic [3:0] word, output logic frame_err);
    word = '0;
    frame_err = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      if (n == 1 && tx_start !== 1'b1) frame_err = 1'b1;
      for (int k = 0; k < 4; k++)
        if (n == 2 + k * 5 + 2) word[k] = tx_data;
      if (n == 24 && tx_data !== 1'b1) frame_err = 1'b1;
      tick();
    end
  endtask

  task automatic test_loopback;
    logic [3:0] rx_word;
    logic       ferr;
    for (int w = 0; w < 16; w++) begin
      do_accept(w[3:0], 1'b0);
      rx_model(rx_word, ferr);
      n_tests++;
      if (rx_word !== w[3:0] || ferr !== 1'b0) begin
        n_fail++;
        $display("FAIL loopback w=%0h: got word %0h frame_err %b, required %0h 0", w, rx_word, ferr, w);
      end
      wait_idle();
    end
  endtask

`ifdef TX_ERR_INJECT_EN
  task automatic test_inject;
    logic [3:0] rx_word;
    logic       ferr;
    inject_err = 1'b1;
    do_accept(4'h3, 1'b0);
    inject_err = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      if (n >= 22 && n <= 26) begin
        n_tests++;
        if (tx_data !== 1'b0) begin
          n_fail++;
          $display("FAIL inject_stop T+%0d: tx_data=%b, required 0", n, tx_data);
        end
      end
      if (n < 27) tick();
    end
    do_accept(4'h3, 1'b1);
    tx_valid = 1'b0;
    rx_model(rx_word, ferr);
    n_tests++;
    if (rx_word !== 4'h3 || ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL inject_clean: got word %0h frame_err %b, required 3 0", rx_word, ferr);
    end
    wait_idle();
  endtask
`endif

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_word  = 4'h0;
`ifdef TX_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    test_reset();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
`ifdef TX_ERR_INJECT_EN
    test_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
